// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 16-bit datapath bus.
// It grants one single-word transfer at a time and adds a wait cycle for synchronous-memory sources.
module bus_arbiter #(
  parameter int NREQ = 4,
  parameter int DSTW = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [4*NREQ-1:0]      src_sel,
  input  logic [DSTW*NREQ-1:0]   dst_we,
  output logic [NREQ-1:0]        done,
  output logic [3:0]             read_en,
  output logic [DSTW-1:0]        wr_en,
  output logic                   mem_rd,
  output logic                   busy,
  output logic                   err
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     cur_id;
  logic [3:0]        cur_src;
  logic [DSTW-1:0]   cur_dst;

  logic [3:0]        src_arr [NREQ];
  logic [DSTW-1:0]   dst_arr [NREQ];
  logic              win_found;
  logic [IW-1:0]     win_id;
  logic [IW-1:0]     nxt_ptr;
  logic [3:0]        sel_src;
  logic [DSTW-1:0]   sel_dst;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      src_arr[i] = src_sel[4*i +: 4];
      dst_arr[i] = dst_we[DSTW*i +: DSTW];
    end
  end

  // Scan from the farthest offset down so the requester nearest ptr is the last writer and wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign nxt_ptr = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
  assign sel_src = src_arr[win_id];
  assign sel_dst = dst_arr[win_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cur_id  <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      read_en <= 4'hF;
      wr_en   <= '0;
      done    <= '0;
      mem_rd  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done   <= '0;
      wr_en  <= '0;
      err    <= 1'b0;
      mem_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur_id  <= win_id;
            cur_src <= sel_src;
            cur_dst <= sel_dst;
            ptr     <= nxt_ptr;
            read_en <= sel_src;
            busy    <= 1'b1;
            if (sel_src <= 4'd1) begin
              state  <= WAIT;
              mem_rd <= 1'b1;
            end else begin
              state <= XFER;
              done  <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
              if (sel_src >= 4'd12) err   <= 1'b1;
              else                  wr_en <= sel_dst;
            end
          end else begin
            read_en <= 4'hF;
            busy    <= 1'b0;
          end
        end
        // Only memory codes reach WAIT, so the write is always legal here.
        WAIT: begin
          state <= XFER;
          done  <= {{(NREQ-1){1'b0}}, 1'b1} << cur_id;
          wr_en <= cur_dst;
        end
        XFER: begin
          state   <= IDLE;
          read_en <= 4'hF;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          read_en <= 4'hF;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected transfers are queued when requests are driven
// and compared against the bus outputs in every cycle that pulses done.
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int DSTW = 12;
  localparam int SBW  = 1 + NREQ + 4 + DSTW;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [4*NREQ-1:0]     src_sel;
  logic [DSTW*NREQ-1:0]  dst_we;
  logic [NREQ-1:0]       done;
  logic [3:0]            read_en;
  logic [DSTW-1:0]       wr_en;
  logic                  mem_rd;
  logic                  busy;
  logic                  err;

  logic [3:0]            src_a [NREQ];
  logic [DSTW-1:0]       dst_a [NREQ];
  logic [SBW-1:0]        exp_q [$];
  int                    checks = 0;
  int                    errors = 0;
  int                    mptr   = 0;

  bus_arbiter #(.NREQ(NREQ), .DSTW(DSTW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_sel(src_sel), .dst_we(dst_we),
    .done(done), .read_en(read_en), .wr_en(wr_en), .mem_rd(mem_rd),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      src_sel[4*i +: 4]       = src_a[i];
      dst_we[DSTW*i +: DSTW]  = dst_a[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] d;
    d     = '0;
    d[id] = 1'b1;
    return d;
  endfunction

  function automatic logic [SBW-1:0] expect_word(input int id, input logic [3:0] src,
                                                 input logic [DSTW-1:0] dst);
    logic e;
    e = (src >= 4'd12);
    return {e, onehot(id), src, (e ? {DSTW{1'b0}} : dst)};
  endfunction

  // One clock: outputs are sampled on the falling edge, and any done cycle is scored.
  task automatic step();
    logic [SBW-1:0] w;
    @(negedge clk);
    if (done !== '0) begin
      check("done_onehot", 64'($onehot(done)), 64'd1);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 64'(done), 64'd0);
      end else begin
        w = exp_q.pop_front();
        check("sb_xfer", 64'({err, done, read_en, wr_en}), 64'(w));
      end
    end
  endtask

  task automatic single_xfer(input int id, input logic [3:0] src, input logic [DSTW-1:0] dst);
    src_a[id] = src;
    dst_a[id] = dst;
    req[id]   = 1'b1;
    exp_q.push_back(expect_word(id, src, dst));
    mptr = (id + 1) % NREQ;
    step();
    if (src <= 4'd1) begin
      check("wait_mem_rd", 64'(mem_rd), 64'd1);
      check("wait_read_en", 64'(read_en), 64'(src));
      check("wait_wr_en", 64'(wr_en), 64'd0);
      check("wait_done", 64'(done), 64'd0);
      step();
    end
    check("xfer_done", 64'(done), 64'(onehot(id)));
    check("xfer_busy", 64'(busy), 64'd1);
    check("xfer_mem_rd", 64'(mem_rd), 64'd0);
    check("xfer_err", 64'(err), 64'(src >= 4'd12));
    req[id] = 1'b0;
    step();
    check("idle_read_en", 64'(read_en), 64'hF);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_err", 64'(err), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_en"}, 64'(read_en), 64'hF);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_a[i] = 4'hF;
      dst_a[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Register source, then dm source.
    single_xfer(0, 4'd4, 12'h010);
    single_xfer(0, 4'd1, 12'h001);

    // All four requesting continuously: strict rotation, one done every 2 cycles.
    for (int i = 0; i < NREQ; i++) begin
      src_a[i] = 4'(2 + i);
      dst_a[i] = 12'h010 << i;
    end
    for (int t = 0; t < 2 * NREQ; t++) begin
      exp_q.push_back(expect_word(mptr, src_a[mptr], dst_a[mptr]));
      mptr = (mptr + 1) % NREQ;
    end
    req = 4'b1111;
    for (int k = 0; k < 4 * NREQ; k++) begin
      step();
      check("rr_cadence", 64'(done !== '0), 64'(k % 2 == 0));
    end
    req = '0;
    step();
    check("rr_idle_busy", 64'(busy), 64'd0);

    // ptr = 3 after serving 2; 1001 held gives 3, then 0 (wrap), then 3 again.
    single_xfer(2, 4'd6, 12'h040);
    src_a[3] = 4'd8;
    dst_a[3] = 12'h080;
    src_a[0] = 4'd9;
    dst_a[0] = 12'h100;
    exp_q.push_back(expect_word(3, 4'd8, 12'h080));
    exp_q.push_back(expect_word(0, 4'd9, 12'h100));
    exp_q.push_back(expect_word(3, 4'd8, 12'h080));
    req = 4'b1001;
    step();
    check("wrap_first", 64'(done), 64'(onehot(3)));
    step();
    step();
    check("wrap_second", 64'(done), 64'(onehot(0)));
    step();
    step();
    check("wrap_third", 64'(done), 64'(onehot(3)));
    req = '0;
    step();
    check("wrap_idle", 64'(busy), 64'd0);
    mptr = 0;

    // Illegal source code, broadcast write, im source with empty dst.
    single_xfer(1, 4'd13, 12'hFFF);
    single_xfer(2, 4'd7, 12'hA5A);
    single_xfer(3, 4'd0, 12'h000);

    // Reset during WAIT abandons the transfer and clears ptr.
    single_xfer(0, 4'd10, 12'h800);
    src_a[1] = 4'd1;
    dst_a[1] = 12'h002;
    req = 4'b0010;
    step();
    check("pre_reset_mem_rd", 64'(mem_rd), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    check("reset_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    src_a[2] = 4'd5;
    dst_a[2] = 12'h020;
    exp_q.push_back(expect_word(1, 4'd1, 12'h002));
    exp_q.push_back(expect_word(2, 4'd5, 12'h020));
    req = 4'b0110;
    step();
    check("rearb_mem_rd", 64'(mem_rd), 64'd1);
    check("rearb_read_en", 64'(read_en), 64'd1);
    step();
    check("rearb_done", 64'(done), 64'(onehot(1)));
    req = 4'b0100;
    step();
    step();
    check("rearb_next", 64'(done), 64'(onehot(2)));
    req = '0;
    step();
    check("final_busy", 64'(busy), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
